// File: rtl/ram2_arb_pkg.sv
// Shared types and RAM2 geometry defaults for the RAM2 round-robin arbiter.
package ram2_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

    localparam int ARB_ADDR_W = 5;
    localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/rr_grant_fsm.sv
// Round-robin grant state machine: holds state, burst counter and last-granted
// pointer; grants are the decoded state register, so they are registered.
module rr_grant_fsm
    import ram2_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_0_i,
    input  logic req_1_i,
    output logic gnt_0_o,
    output logic gnt_1_o
);

    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             go0, go1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        go0     = 1'b0;
        go1     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (req_0_i && req_1_i) begin
                    go0 = last_q;
                    go1 = !last_q;
                end else begin
                    go0 = req_0_i;
                    go1 = req_1_i;
                end
            end
            ARB_GRANT0: begin
                if (!req_0_i) begin
                    if (req_1_i) go1 = 1'b1;
                    else         state_d = ARB_IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (req_1_i) begin
                    go1 = 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            ARB_GRANT1: begin
                if (!req_1_i) begin
                    if (req_0_i) go0 = 1'b1;
                    else         state_d = ARB_IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (req_0_i) begin
                    go0 = 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // Entering a grant state restarts the burst and records the winner.
        if (go0) begin
            state_d = ARB_GRANT0;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (go1) begin
            state_d = ARB_GRANT1;
            cnt_d   = '0;
            last_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_0_o = (state_q == ARB_GRANT0);
    assign gnt_1_o = (state_q == ARB_GRANT1);

endmodule

// File: rtl/ram2_rr_arbiter.sv
// Shares RAM2's write port and read port 0 between two requesters; read data
// comes back one cycle after the access, registered per requester.
module ram2_rr_arbiter
    import ram2_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic [ADDR_W-1:0] raddr0,
    input  logic [DATA_W-1:0] rdata0,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wen
);

    logic              acc_0, acc_1;
    logic              rd_0, rd_1;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_0_q, rdata_1_q;

    rr_grant_fsm #(
        .BURST (BURST)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .req_0_i (req_0),
        .req_1_i (req_1),
        .gnt_0_o (gnt_0),
        .gnt_1_o (gnt_1)
    );

    assign acc_0 = gnt_0 && req_0;
    assign acc_1 = gnt_1 && req_1;
    assign rd_0  = acc_0 && !we_0;
    assign rd_1  = acc_1 && !we_1;

    // Unused RAM pins are forced to zero so idle cycles are clean on the bus.
    always_comb begin
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr0 = '0;
        if (acc_0) begin
            if (we_0) begin
                wen   = 1'b1;
                waddr = addr_0;
                wdata = wdata_0;
            end else begin
                raddr0 = addr_0;
            end
        end else if (acc_1) begin
            if (we_1) begin
                wen   = 1'b1;
                waddr = addr_1;
                wdata = wdata_1;
            end else begin
                raddr0 = addr_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q  <= 2'b00;
            rdata_0_q <= '0;
            rdata_1_q <= '0;
        end else begin
            rvalid_q <= {rd_1, rd_0};
            if (rd_0) rdata_0_q <= rdata0;
            if (rd_1) rdata_1_q <= rdata0;
        end
    end

    assign rvalid_0 = rvalid_q[0];
    assign rvalid_1 = rvalid_q[1];
    assign rdata_0  = rdata_0_q;
    assign rdata_1  = rdata_1_q;

endmodule

// File: tb/tb_ram2_rr_arbiter.sv
// Directed bench for ram2_rr_arbiter with a behavioural RAM2 model attached.
module tb_ram2_rr_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int BURST  = 4;

    logic              clk;
    logic              rst;
    logic              req_0, req_1, we_0, we_1;
    logic [ADDR_W-1:0] addr_0, addr_1;
    logic [DATA_W-1:0] wdata_0, wdata_1;
    logic              gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DATA_W-1:0] rdata_0, rdata_1;
    logic [ADDR_W-1:0] raddr0, waddr;
    logic [DATA_W-1:0] rdata0, wdata;
    logic              wen;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_chk;
    int n_pass;

    ram2_rr_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BURST  (BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_0    (req_0),
        .req_1    (req_1),
        .we_0     (we_0),
        .we_1     (we_1),
        .addr_0   (addr_0),
        .addr_1   (addr_1),
        .wdata_0  (wdata_0),
        .wdata_1  (wdata_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .rvalid_0 (rvalid_0),
        .rvalid_1 (rvalid_1),
        .rdata_0  (rdata_0),
        .rdata_1  (rdata_1),
        .raddr0   (raddr0),
        .rdata0   (rdata0),
        .waddr    (waddr),
        .wdata    (wdata),
        .wen      (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM2 model: combinational read port 0, write at the clock edge.
    assign rdata0 = mem[raddr0];
    always @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g, prev_g;
        n_chk = 0;
        n_pass = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[0] = 32'd17;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        mem[3] = 32'h33;
        mem[4] = 32'h44;

        rst = 1'b1;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        repeat (2) step();
        chk("rst_gnt", {gnt_1, gnt_0}, 2'b00);
        chk("rst_rvalid", {rvalid_1, rvalid_0}, 2'b00);
        chk("rst_wen", wen, 1'b0);
        chk("rst_rdata0", rdata_0, 0);
        chk("rst_rdata1", rdata_1, 0);
        rst = 1'b0;
        step();

        // Single write by requester 0.
        req_0 = 1; we_0 = 1; addr_0 = 5'd10; wdata_0 = 32'd10;
        #1;
        chk("wr_no_gnt_yet", gnt_0, 1'b0);
        chk("wr_no_wen_yet", wen, 1'b0);
        step();
        chk("wr_gnt0", gnt_0, 1'b1);
        chk("wr_wen", wen, 1'b1);
        chk("wr_waddr", waddr, 10);
        chk("wr_wdata", wdata, 10);
        step();
        req_0 = 0; we_0 = 0;
        #1;
        chk("wr_idle_wen", wen, 1'b0);
        chk("wr_idle_waddr", waddr, 0);
        step();
        chk("wr_to_idle", {gnt_1, gnt_0}, 2'b00);
        chk("wr_mem10", mem[10], 10);

        // Single read by requester 1 of address 0.
        req_1 = 1; we_1 = 0; addr_1 = 5'd0;
        step();
        chk("rd_gnt1", {gnt_1, gnt_0}, 2'b10);
        chk("rd_wen", wen, 1'b0);
        chk("rd_rvalid_early", {rvalid_1, rvalid_0}, 2'b00);
        step();
        chk("rd_rvalid1", {rvalid_1, rvalid_0}, 2'b10);
        chk("rd_rdata1", rdata_1, 17);
        req_1 = 0;
        step();
        chk("rd_rvalid_pulse", {rvalid_1, rvalid_0}, 2'b00);
        chk("rd_rdata1_hold", rdata_1, 17);
        step();

        // Continuous contention from reset.
        rst = 1; step();
        rst = 0;
        req_0 = 1; we_0 = 0; addr_0 = 5'd1;
        req_1 = 1; we_1 = 0; addr_1 = 5'd2;
        prev_g = 2'b00;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_g = (i < 4) ? 2'b01 : ((i < 8) ? 2'b10 : 2'b01);
            chk($sformatf("cont_gnt_%0d", i), {gnt_1, gnt_0}, exp_g);
            chk($sformatf("cont_rvalid_%0d", i), {rvalid_1, rvalid_0}, prev_g);
            if (prev_g == 2'b01) chk($sformatf("cont_rdata0_%0d", i), rdata_0, 32'h11);
            if (prev_g == 2'b10) chk($sformatf("cont_rdata1_%0d", i), rdata_1, 32'h22);
            prev_g = exp_g;
        end
        req_0 = 0; req_1 = 0;
        step();
        chk("cont_to_idle", {gnt_1, gnt_0}, 2'b00);

        // Lone requester 0 held: never preempted, counter wraps silently.
        req_0 = 1; we_0 = 0; addr_0 = 5'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("lone_gnt_%0d", i), {gnt_1, gnt_0}, 2'b01);
        end
        req_0 = 0;
        step();
        chk("lone_to_idle", {gnt_1, gnt_0}, 2'b00);
        chk("lone_rdata0", rdata_0, 32'h33);

        // Handover at burst end with a read by 0 in the last granted cycle.
        req_0 = 1; addr_0 = 5'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ho_gnt0_%0d", i), gnt_0, 1'b1);
        end
        addr_0 = 5'd4;
        req_1 = 1; we_1 = 0; addr_1 = 5'd1;
        #1;
        chk("ho_raddr0", raddr0, 4);
        step();
        chk("ho_gnt1", {gnt_1, gnt_0}, 2'b10);
        chk("ho_rvalid0", {rvalid_1, rvalid_0}, 2'b01);
        chk("ho_rdata0", rdata_0, 32'h44);

        // Reset lands on the read by 1: return dropped, outputs cleared.
        req_0 = 0; rst = 1;
        #1;
        chk("rr_raddr0", raddr0, 1);
        step();
        chk("rr_gnt", {gnt_1, gnt_0}, 2'b00);
        chk("rr_rvalid", {rvalid_1, rvalid_0}, 2'b00);
        chk("rr_wen", wen, 1'b0);
        chk("rr_rdata0", rdata_0, 0);
        chk("rr_rdata1", rdata_1, 0);
        rst = 0; req_0 = 1;
        step();
        chk("rr_tie_gnt0", {gnt_1, gnt_0}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
